// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, data width and the baud divider map
// used by both the transmitter and the receiver.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE           = 3'd0,
    START_BIT      = 3'd1,
    DATA           = 3'd2,
    PARITY         = 3'd3,
    STOP_BIT_FIRST = 3'd4,
    STOP_BIT_LAST  = 3'd5
  } uart_state_e;

  // One bit period is baud_div()+1 clock cycles.
  function automatic logic [15:0] baud_div(input logic [31:0] baudrate);
    case (baudrate)
      32'd9600:   baud_div = 16'd1041;
      32'd19200:  baud_div = 16'd520;
      32'd38400:  baud_div = 16'd259;
      32'd57600:  baud_div = 16'd173;
      32'd115200: baud_div = 16'd86;
      default:    baud_div = 16'd1041;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle
// (high) level so the receiver never sees a spurious start bit out of reset.
module uart_rx_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[0], d_i};
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sync_q <= 2'b11;
    else       sync_q <= sync_d;
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start bit, 8 data bits LSB first, optional even parity, 1 or 2 stop bits.
// Define UART_RX_MAJORITY_EN to take each bit decision from a 2-of-3 vote around the sample point.
import uart_pkg::*;

module uart_rx (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rx_i,
  input  logic [31:0] baudrate_i,
  input  logic        parity_en_i,
  input  logic        stopbit_i,
  output logic [7:0]  rx_data_o,
  output logic        rx_valid_o,
  output logic        parity_err_o,
  output logic        frame_err_o,
  output logic        busy_o
);

  uart_state_e state_q, state_d;
  logic [15:0] div;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        par_acc_q, par_acc_d;
  logic        par_bad_q, par_bad_d;
  logic        frm_bad_q, frm_bad_d;
  logic        rx_valid_q, rx_valid_d;
  logic        parity_err_q, parity_err_d;
  logic        frame_err_q, frame_err_d;
  logic        rxs, at_sample, sample_fire, sample_bit, complete;

  uart_rx_sync u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (rx_i),
    .q_o   (rxs)
  );

  assign div       = baud_div(baudrate_i);
  // The start bit is checked half a bit in so that all later samples land mid-bit.
  assign at_sample = (state_q == START_BIT) ? (cnt_q == (div >> 1)) : (cnt_q == div);

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist_q, hist_d;
  logic       pend_q, pend_d;

  always_comb begin
    hist_d = {hist_q[0], rxs};
    pend_d = at_sample && (state_q != IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hist_q <= 2'b11;
      pend_q <= 1'b0;
    end else begin
      hist_q <= hist_d;
      pend_q <= pend_d;
    end
  end

  // Decision one cycle after the nominal point, voting over samples c-1, c, c+1.
  assign sample_fire = pend_q;
  assign sample_bit  = (hist_q[1] & hist_q[0]) | (hist_q[1] & rxs) | (hist_q[0] & rxs);
`else
  assign sample_fire = at_sample;
  assign sample_bit  = rxs;
`endif

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    state_d      = state_q;
    cnt_d        = (at_sample && state_q != START_BIT) ? 16'd0 : cnt_q + 16'd1;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_acc_d    = par_acc_q;
    par_bad_d    = par_bad_q;
    frm_bad_d    = frm_bad_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    complete     = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = 16'd0;
        if (!rxs) state_d = START_BIT;
      end
      START_BIT: begin
        if (sample_fire) begin
          if (!sample_bit) begin
            state_d   = DATA;
            cnt_d     = 16'd0;
            bit_cnt_d = 3'd0;
            par_acc_d = 1'b0;
            par_bad_d = 1'b0;
            frm_bad_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (sample_fire) begin
          shift_d   = {sample_bit, shift_q[7:1]};
          par_acc_d = par_acc_q ^ sample_bit;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'(UART_DATA_BITS - 1))
            state_d = parity_en_i ? PARITY : STOP_BIT_FIRST;
        end
      end
      PARITY: begin
        if (sample_fire) begin
          par_bad_d = par_acc_q ^ sample_bit;
          state_d   = STOP_BIT_FIRST;
        end
      end
      STOP_BIT_FIRST: begin
        if (sample_fire) begin
          frm_bad_d = ~sample_bit;
          if (stopbit_i) state_d = STOP_BIT_LAST;
          else           complete = 1'b1;
        end
      end
      STOP_BIT_LAST: begin
        if (sample_fire) begin
          frm_bad_d = frm_bad_q | ~sample_bit;
          complete  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (complete) begin
      state_d      = IDLE;
      rx_data_d    = shift_q;
      parity_err_d = par_bad_q;
      frame_err_d  = frm_bad_d;
      rx_valid_d   = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      cnt_q        <= 16'd0;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'h00;
      par_acc_q    <= 1'b0;
      par_bad_q    <= 1'b0;
      frm_bad_q    <= 1'b0;
      rx_data_q    <= 8'h00;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_acc_q    <= par_acc_d;
      par_bad_q    <= par_bad_d;
      frm_bad_q    <= frm_bad_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign rx_data_o    = rx_data_q;
  assign rx_valid_o   = rx_valid_q;
  assign parity_err_o = parity_err_q;
  assign frame_err_o  = frame_err_q;
  assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx: drives serial frames bit by bit and checks the
// recovered bytes, error flags, busy and the valid pulse against hand-computed values.
module tb_uart_rx;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        rx_i = 1'b1;
  logic [31:0] baudrate_i = 32'd115200;
  logic        parity_en_i = 1'b0;
  logic        stopbit_i = 1'b0;
  logic [7:0]  rx_data_o;
  logic        rx_valid_o;
  logic        parity_err_o;
  logic        frame_err_o;
  logic        busy_o;

  int checks = 0;
  int errors = 0;

  int         valid_cnt = 0;
  int         err_seen = 0;
  int         long_pulse = 0;
  logic       prev_valid = 1'b0;
  logic [7:0] rx_log[$];

  uart_rx dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .rx_i         (rx_i),
    .baudrate_i   (baudrate_i),
    .parity_en_i  (parity_en_i),
    .stopbit_i    (stopbit_i),
    .rx_data_o    (rx_data_o),
    .rx_valid_o   (rx_valid_o),
    .parity_err_o (parity_err_o),
    .frame_err_o  (frame_err_o),
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Receive monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk_i) begin
    if (rx_valid_o) begin
      valid_cnt <= valid_cnt + 1;
      rx_log.push_back(rx_data_o);
      if (parity_err_o || frame_err_o) err_seen <= err_seen + 1;
      if (prev_valid) long_pulse <= long_pulse + 1;
    end
    prev_valid <= rx_valid_o;
  end

  task automatic drive_bit(input logic v, input int n);
    rx_i = v;
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  // A low last stop bit is held low just past mid-bit, then released for the rest of the bit.
  task automatic send_frame(input logic [7:0] data, input logic par_en, input logic par_bit,
                            input logic two_stop, input logic last_stop, input int bc);
    drive_bit(1'b0, bc);
    for (int i = 0; i < 8; i++) drive_bit(data[i], bc);
    if (par_en) drive_bit(par_bit, bc);
    if (two_stop) drive_bit(1'b1, bc);
    if (last_stop) begin
      drive_bit(1'b1, bc);
    end else begin
      drive_bit(1'b0, bc / 2 + 10);
      drive_bit(1'b1, bc - bc / 2 - 10);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk_i);
    #1;
    checks++; if (rx_data_o !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", rx_data_o); end
    checks++; if (rx_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", rx_valid_o); end
    checks++; if (parity_err_o !== 1'b0) begin errors++; $display("FAIL reset_parity_err: got %b expected 0", parity_err_o); end
    checks++; if (frame_err_o !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", frame_err_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
    rst_i = 1'b0;
    repeat (5) @(posedge clk_i);
    #1;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", busy_o); end
  endtask

  task automatic test_basic();
    int v0;
    baudrate_i = 32'd115200; parity_en_i = 1'b0; stopbit_i = 1'b0;
    v0 = valid_cnt;
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 87);
    repeat (5) @(posedge clk_i);
    #1;
    checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL basic_valid_count: got %0d expected 1", valid_cnt - v0); end
    checks++; if (rx_data_o !== 8'h55) begin errors++; $display("FAIL basic_data: got %h expected 55", rx_data_o); end
    checks++; if (parity_err_o !== 1'b0) begin errors++; $display("FAIL basic_parity_err: got %b expected 0", parity_err_o); end
    checks++; if (frame_err_o !== 1'b0) begin errors++; $display("FAIL basic_frame_err: got %b expected 0", frame_err_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL basic_busy: got %b expected 0", busy_o); end
    checks++; if (long_pulse !== 0) begin errors++; $display("FAIL basic_pulse_width: got %0d long pulses expected 0", long_pulse); end
  endtask

  task automatic test_parity();
    int v0;
    baudrate_i = 32'd115200; parity_en_i = 1'b1; stopbit_i = 1'b0;
    v0 = valid_cnt;
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 87);
    repeat (5) @(posedge clk_i);
    #1;
    checks++; if (rx_data_o !== 8'hA5) begin errors++; $display("FAIL parity_good_data: got %h expected a5", rx_data_o); end
    checks++; if (parity_err_o !== 1'b0) begin errors++; $display("FAIL parity_good_err: got %b expected 0", parity_err_o); end
    send_frame(8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 87);
    repeat (5) @(posedge clk_i);
    #1;
    checks++; if (parity_err_o !== 1'b1) begin errors++; $display("FAIL parity_bad_err: got %b expected 1", parity_err_o); end
    checks++; if (rx_data_o !== 8'hA5) begin errors++; $display("FAIL parity_bad_data: got %h expected a5", rx_data_o); end
    checks++; if (frame_err_o !== 1'b0) begin errors++; $display("FAIL parity_bad_frame_err: got %b expected 0", frame_err_o); end
    checks++; if (valid_cnt - v0 !== 2) begin errors++; $display("FAIL parity_valid_count: got %0d expected 2", valid_cnt - v0); end
  endtask

  task automatic test_two_stop();
    int v0;
    baudrate_i = 32'd115200; parity_en_i = 1'b0; stopbit_i = 1'b1;
    v0 = valid_cnt;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 87);
    repeat (2 * 87) @(posedge clk_i);
    #1;
    checks++; if (frame_err_o !== 1'b1) begin errors++; $display("FAIL stop2_low_frame_err: got %b expected 1", frame_err_o); end
    checks++; if (rx_data_o !== 8'h3C) begin errors++; $display("FAIL stop2_low_data: got %h expected 3c", rx_data_o); end
    checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL stop2_low_valid_count: got %0d expected 1", valid_cnt - v0); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL stop2_low_busy: got %b expected 0", busy_o); end
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b1, 87);
    repeat (5) @(posedge clk_i);
    #1;
    checks++; if (frame_err_o !== 1'b0) begin errors++; $display("FAIL stop2_high_frame_err: got %b expected 0", frame_err_o); end
    checks++; if (valid_cnt - v0 !== 2) begin errors++; $display("FAIL stop2_high_valid_count: got %0d expected 2", valid_cnt - v0); end
  endtask

  task automatic test_glitch();
    int v0;
    baudrate_i = 32'd9600; parity_en_i = 1'b0; stopbit_i = 1'b0;
    v0 = valid_cnt;
    drive_bit(1'b0, 20);
    drive_bit(1'b1, 10);
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL glitch_busy_start: got %b expected 1", busy_o); end
    repeat (600) @(posedge clk_i);
    #1;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL glitch_busy_end: got %b expected 0", busy_o); end
    checks++; if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL glitch_no_valid: got %0d expected 0", valid_cnt - v0); end
    send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 1042);
    repeat (5) @(posedge clk_i);
    #1;
    checks++; if (rx_data_o !== 8'h81) begin errors++; $display("FAIL glitch_next_data: got %h expected 81", rx_data_o); end
    checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL glitch_next_valid: got %0d expected 1", valid_cnt - v0); end
    checks++; if (frame_err_o !== 1'b0) begin errors++; $display("FAIL glitch_next_frame_err: got %b expected 0", frame_err_o); end
  endtask

  // Stands in for the transmitter: frames sent back to back, even parity, one stop bit.
  task automatic test_loopback();
    logic [7:0] bytes [4];
    int v0, e0, base;
    bytes = '{8'h00, 8'hFF, 8'h7E, 8'h01};
    baudrate_i = 32'd57600; parity_en_i = 1'b1; stopbit_i = 1'b0;
    v0 = valid_cnt; e0 = err_seen; base = rx_log.size();
    for (int i = 0; i < 4; i++) send_frame(bytes[i], 1'b1, ^bytes[i], 1'b0, 1'b1, 174);
    repeat (10) @(posedge clk_i);
    #1;
    checks++; if (valid_cnt - v0 !== 4) begin errors++; $display("FAIL loop_count: got %0d expected 4", valid_cnt - v0); end
    checks++; if (err_seen - e0 !== 0) begin errors++; $display("FAIL loop_errors: got %0d flagged frames expected 0", err_seen - e0); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rx_log.size() <= base + i) begin
        errors++; $display("FAIL loop_byte%0d: missing expected %h", i, bytes[i]);
      end else if (rx_log[base + i] !== bytes[i]) begin
        errors++; $display("FAIL loop_byte%0d: got %h expected %h", i, rx_log[base + i], bytes[i]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int v0;
    baudrate_i = 32'd115200; parity_en_i = 1'b0; stopbit_i = 1'b0;
    drive_bit(1'b0, 87);
    for (int i = 0; i < 3; i++) drive_bit(1'b1, 87);
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL midrst_busy_before: got %b expected 1", busy_o); end
    v0 = valid_cnt;
    rst_i = 1'b1;
    #1;
    checks++; if (rx_data_o !== 8'h00) begin errors++; $display("FAIL midrst_data: got %h expected 00", rx_data_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy_o); end
    checks++; if (rx_valid_o !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b expected 0", rx_valid_o); end
    rx_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    repeat (2 * 87) @(posedge clk_i);
    #1;
    checks++; if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL midrst_no_valid: got %0d expected 0", valid_cnt - v0); end
    send_frame(8'h12, 1'b0, 1'b0, 1'b0, 1'b1, 87);
    repeat (5) @(posedge clk_i);
    #1;
    checks++; if (rx_data_o !== 8'h12) begin errors++; $display("FAIL midrst_next_data: got %h expected 12", rx_data_o); end
    checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL midrst_next_valid: got %0d expected 1", valid_cnt - v0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_two_stop();
    test_glitch();
    test_loopback();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
